// File: rtl/video_in_dma_store_pkg.sv
// video_in_pkg: shared DMA state type and frame sizing helper for the video_in store path
package video_in_pkg;
    typedef enum logic [2:0] {IDLE, ARM, WAITD, BURST, FDONE, BERR} dma_state_t;
    function automatic int frame_words(input int w, input int h, input int bpp);
        return w * h * bpp / 4;
    endfunction
endpackage

// File: rtl/video_in_dma_store_if.sv
// video_in_dma_store_if: Wishbone classic write-master bundle
interface video_in_dma_store_if;
    logic        p_wb_CYC_O;
    logic        p_wb_STB_O;
    logic        p_wb_WE_O;
    logic        p_wb_LOCK_O;
    logic [3:0]  p_wb_SEL_O;
    logic [31:0] p_wb_ADR_O;
    logic [31:0] p_wb_DAT_O;
    logic        p_wb_ACK_I;
    logic        p_wb_ERR_I;
    modport master (
        output p_wb_CYC_O, p_wb_STB_O, p_wb_WE_O, p_wb_LOCK_O, p_wb_SEL_O, p_wb_ADR_O, p_wb_DAT_O,
        input  p_wb_ACK_I, p_wb_ERR_I
    );
    modport slave (
        input  p_wb_CYC_O, p_wb_STB_O, p_wb_WE_O, p_wb_LOCK_O, p_wb_SEL_O, p_wb_ADR_O, p_wb_DAT_O,
        output p_wb_ACK_I, p_wb_ERR_I
    );
endinterface

// File: rtl/video_in_dma_store_irq_stretch.sv
// video_in_irq_stretch: turns a one-cycle start into an IRQ_CYCLES-long pulse with a last-cycle flag
module video_in_irq_stretch #(
    parameter int IRQ_CYCLES = 3
) (
    input  logic clk,
    input  logic RST,
    input  logic start,
    output logic irq,
    output logic done
);
    localparam int CW = $clog2(IRQ_CYCLES + 1);
    logic [CW-1:0] cnt;
    // Load the pulse length on start and count it down while the interrupt is held
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            cnt <= '0;
            irq <= 1'b0;
        end else if (start) begin
            cnt <= CW'(IRQ_CYCLES);
            irq <= 1'b1;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            irq <= cnt != CW'(1);
        end
    end
    assign done = cnt == CW'(1);
endmodule

// File: rtl/video_in_dma_store.sv
// video_in_dma_store: ping-pong frame-buffer burst writer draining the pixel FIFO onto Wishbone
module video_in_dma_store
    import video_in_pkg::*;
#(
    parameter int P_WIDTH    = 640,
    parameter int P_HEIGHT   = 480,
    parameter int P_BPP      = 1,
    parameter int BURST_LEN  = 16,
    parameter int NB_BUF     = 2,
    parameter int IRQ_CYCLES = 3
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [31:0] cfg_base0,
    input  logic [31:0] cfg_base1,
    input  logic        cfg_go,
    input  logic        cfg_cont,
    input  logic        fifo_burst_avl,
    input  logic [31:0] fifo_data,
    output logic        fifo_rd,
    output logic        irq_frame,
    output logic        irq_err,
    output logic        busy,
    output logic        cur_buf,
    video_in_dma_store_if.master wb
);
    localparam int FRAME_WORDS = frame_words(P_WIDTH, P_HEIGHT, P_BPP);
    localparam int FWW = $clog2(FRAME_WORDS + 1);
    localparam int BW = $clog2(BURST_LEN + 1);

    if (FRAME_WORDS % BURST_LEN != 0 || (BURST_LEN & (BURST_LEN - 1)) != 0) begin : g_bad_burst
        $error("BURST_LEN must be a power of two dividing the frame size");
    end
    if (IRQ_CYCLES < 3 || (NB_BUF != 1 && NB_BUF != 2)) begin : g_bad_cfg
        $error("IRQ_CYCLES must be >= 3 and NB_BUF 1 or 2");
    end

    dma_state_t     state;
    logic [FWW-1:0] frame_word;
    logic [BW-1:0]  beat;
    logic [31:0]    adr;
    logic [31:0]    dat;
    logic           bus_act;
    logic           frame_go;
    logic           err_go;
    logic           frame_done;
    logic           err_done;

    wire bus_err  = bus_act & wb.p_wb_ERR_I;
    wire good_ack = bus_act & wb.p_wb_ACK_I & ~wb.p_wb_ERR_I;
    wire last     = beat == BW'(BURST_LEN - 1);
    wire frame_end = frame_word == FWW'(FRAME_WORDS - 1);

    assign fifo_rd = (state == WAITD && fifo_burst_avl) || (state == BURST && good_ack && !last);
    assign busy    = state != IDLE;
    assign wb.p_wb_CYC_O  = bus_act;
    assign wb.p_wb_STB_O  = bus_act;
    assign wb.p_wb_WE_O   = bus_act;
    assign wb.p_wb_LOCK_O = bus_act;
    assign wb.p_wb_SEL_O  = 4'hf;
    assign wb.p_wb_ADR_O  = adr;
    assign wb.p_wb_DAT_O  = dat;

    // Frame sequencer: owns the bus cycle, address/data registers and buffer selection
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            bus_act    <= 1'b0;
            adr        <= '0;
            dat        <= '0;
            frame_word <= '0;
            beat       <= '0;
            cur_buf    <= 1'b0;
            frame_go   <= 1'b0;
            err_go     <= 1'b0;
        end else begin
            frame_go <= 1'b0;
            err_go   <= 1'b0;
            case (state)
                IDLE: state <= cfg_go ? ARM : IDLE;
                ARM: begin
                    frame_word <= '0;
                    adr        <= (NB_BUF == 2 && cur_buf) ? cfg_base1 : cfg_base0;
                    state      <= WAITD;
                end
                WAITD: if (fifo_burst_avl) begin
                    bus_act <= 1'b1;
                    dat     <= fifo_data;
                    beat    <= '0;
                    state   <= BURST;
                end
                BURST: if (bus_err) begin
                    bus_act <= 1'b0;
                    err_go  <= 1'b1;
                    state   <= BERR;
                end else if (good_ack) begin
                    frame_word <= frame_word + FWW'(1);
                    beat       <= beat + BW'(1);
                    adr        <= adr + 32'd4;
                    if (last) begin
                        bus_act  <= 1'b0;
                        frame_go <= frame_end;
                        state    <= frame_end ? FDONE : WAITD;
                    end else begin
                        dat <= fifo_data;
                    end
                end
                FDONE: if (frame_done) begin
                    cur_buf <= NB_BUF == 2 ? ~cur_buf : cur_buf;
                    state   <= cfg_cont ? ARM : IDLE;
                end
                BERR: state <= err_done ? IDLE : BERR;
                default: state <= IDLE;
            endcase
        end
    end

    video_in_irq_stretch #(.IRQ_CYCLES(IRQ_CYCLES)) u_irq_frame (
        .clk(clk), .RST(RST), .start(frame_go), .irq(irq_frame), .done(frame_done)
    );
    video_in_irq_stretch #(.IRQ_CYCLES(IRQ_CYCLES)) u_irq_err (
        .clk(clk), .RST(RST), .start(err_go), .irq(irq_err), .done(err_done)
    );
endmodule

// File: tb/tb_video_in_dma_store.sv
// tb_video_in_dma_store: randomized bench against a frame/word-level model of the DMA store
module tb_video_in_dma_store;
    localparam int FW = 16;
    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] cfg_base0 = 32'h1000;
    logic [31:0] cfg_base1 = 32'h8000;
    logic        cfg_go = 1'b0;
    logic        cfg_cont = 1'b0;
    logic        fifo_burst_avl = 1'b0;
    logic [31:0] fifo_data = '0;
    logic        fifo_rd, irq_frame, irq_err, busy, cur_buf;

    video_in_dma_store_if wb();

    video_in_dma_store #(
        .P_WIDTH(8), .P_HEIGHT(2), .P_BPP(4), .BURST_LEN(4), .NB_BUF(2), .IRQ_CYCLES(3)
    ) dut (
        .clk(clk), .RST(RST), .cfg_base0(cfg_base0), .cfg_base1(cfg_base1), .cfg_go(cfg_go),
        .cfg_cont(cfg_cont), .fifo_burst_avl(fifo_burst_avl), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
        .irq_frame(irq_frame), .irq_err(irq_err), .busy(busy), .cur_buf(cur_buf), .wb(wb)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_ok = 0;
    logic [31:0] fifo_q[$];
    logic [31:0] popped[$];
    logic [31:0] mbase = '0;
    logic pend_pop = 0, frame_active = 0, mbuf = 0, avl_en = 0, avl_rand = 0, err_rand = 0;
    int mk = 0, ack_mode = 0, err_at = -1, tick = 0, cont_stop = -1;
    int frames_done = 0, exp_err = 0, fr_len = 0, er_len = 0, fr_cnt = 0, er_cnt = 0, cyc_hi = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic start_frame();
        frame_active = 1;
        mk = 0;
        popped.delete();
        mbase = mbuf ? cfg_base1 : cfg_base0;
    endtask

    task automatic observe();
        if (!frame_active) begin
            check("rd_idle", 32'(fifo_rd), 0);
            check("stb_idle", 32'(wb.p_wb_STB_O), 0);
        end
        if (fifo_rd) begin
            popped.push_back(fifo_data);
            pend_pop = 1;
        end
        if (wb.p_wb_STB_O && wb.p_wb_ERR_I) begin
            check("err_pops", popped.size(), mk + 1);
            frame_active = 0;
            exp_err++;
        end else if (wb.p_wb_STB_O && wb.p_wb_ACK_I && frame_active) begin
            check("adr", wb.p_wb_ADR_O, mbase + 32'(4 * mk));
            if (mk < popped.size()) check("dat", wb.p_wb_DAT_O, popped[mk]);
            else check("dat_avail", popped.size(), mk + 1);
            check("cyc_we_lock_sel", 32'({wb.p_wb_CYC_O, wb.p_wb_WE_O, wb.p_wb_LOCK_O, wb.p_wb_SEL_O}), 32'h7f);
            mk++;
            if (mk == FW) begin
                check("frame_pops", popped.size(), FW);
                frames_done++;
                mbuf = ~mbuf;
                if (cfg_cont) start_frame();
                else frame_active = 0;
            end
        end
        if (cont_stop >= 0 && frames_done == cont_stop && mk >= 1) begin
            cfg_cont = 0;
            cont_stop = -1;
        end
        if (irq_frame) fr_len++;
        else if (fr_len != 0) begin
            check("irq_frame_len", fr_len, 3);
            fr_cnt++;
            fr_len = 0;
        end
        if (irq_err) er_len++;
        else if (er_len != 0) begin
            check("irq_err_len", er_len, 3);
            er_cnt++;
            er_len = 0;
        end
        cyc_hi += int'(wb.p_wb_CYC_O);
    endtask

    task automatic step();
        @(negedge clk);
        if (pend_pop) void'(fifo_q.pop_front());
        pend_pop = 0;
        while (fifo_q.size() < 40) fifo_q.push_back($urandom);
        fifo_data = fifo_q[0];
        fifo_burst_avl = avl_en && (!avl_rand || $urandom_range(3) != 0);
        tick++;
        wb.p_wb_ACK_I = ack_mode == 0 ? 1'b1 : ack_mode == 1 ? (tick % 3 == 0) : 1'($urandom_range(1));
        wb.p_wb_ERR_I = (err_at >= 0 && mk == err_at && frame_active && wb.p_wb_STB_O)
                        || (err_rand && $urandom_range(39) == 0);
        #1;
        observe();
    endtask

    task automatic go();
        start_frame();
        cfg_go = 1;
        step();
        cfg_go = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        repeat (3) step();
        while (busy && n < budget) begin
            step();
            n++;
        end
        check("idle_timeout", 32'(busy), 0);
    endtask

    initial begin
        int f0, n;
        wb.p_wb_ACK_I = 0;
        wb.p_wb_ERR_I = 0;
        repeat (3) step();
        check("rst_cyc", 32'(wb.p_wb_CYC_O), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_irq", 32'({irq_frame, irq_err}), 0);
        check("rst_cur_buf", 32'(cur_buf), 0);
        check("rst_adr", wb.p_wb_ADR_O, 0);
        RST = 0;
        avl_en = 1;

        go();
        wait_idle(500);
        check("t1_irq_frames", fr_cnt, 1);
        check("t1_cur_buf", 32'(cur_buf), 32'(mbuf));

        ack_mode = 1;
        go();
        wait_idle(500);
        check("t2_irq_frames", fr_cnt, frames_done);
        check("t2_cur_buf", 32'(cur_buf), 32'(mbuf));

        ack_mode = 2;
        avl_rand = 1;
        cfg_cont = 1;
        f0 = fr_cnt;
        cont_stop = frames_done + 2;
        go();
        wait_idle(3000);
        check("t3_frames", fr_cnt - f0, 3);
        check("t3_cur_buf", 32'(cur_buf), 32'(mbuf));

        ack_mode = 0;
        avl_rand = 0;
        err_at = 8;
        go();
        wait_idle(500);
        err_at = -1;
        check("t4_irq_err", er_cnt, 1);
        check("t4_cur_buf", 32'(cur_buf), 32'(mbuf));

        avl_en = 0;
        cyc_hi = 0;
        go();
        repeat (20) step();
        cfg_go = 1;
        step();
        cfg_go = 0;
        cfg_base0 = 32'h2000;
        cfg_base1 = 32'h9000;
        repeat (29) step();
        check("t5_cyc_held", cyc_hi, 0);
        check("t5_busy", 32'(busy), 1);
        avl_en = 1;
        wait_idle(500);
        check("t5_irq_frames", fr_cnt, frames_done);

        go();
        n = 0;
        while (!(wb.p_wb_CYC_O && mk >= 2) && n < 200) begin
            step();
            n++;
        end
        check("t6_mid_burst", 32'(wb.p_wb_CYC_O), 1);
        #2 RST = 1;
        #1;
        check("t6_rst_bus", 32'({wb.p_wb_CYC_O, wb.p_wb_STB_O, fifo_rd}), 0);
        check("t6_rst_irq", 32'({irq_frame, irq_err, busy}), 0);
        pend_pop = 0;
        frame_active = 0;
        mbuf = 0;
        fr_len = 0;
        er_len = 0;
        repeat (2) step();
        RST = 0;
        check("t6_cur_buf", 32'(cur_buf), 0);
        go();
        wait_idle(500);
        check("t6_irq_frames", fr_cnt, frames_done);

        ack_mode = 2;
        avl_rand = 1;
        err_rand = 1;
        repeat (6) begin
            go();
            wait_idle(2000);
        end
        err_rand = 0;
        repeat (2) step();
        check("rand_irq_frames", fr_cnt, frames_done);
        check("rand_irq_err", er_cnt, exp_err);
        check("rand_cur_buf", 32'(cur_buf), 32'(mbuf));

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
